// File: rtl/spi_controller.sv
// spi_controller: SPI mode-0 controller that sends one 16-bit frame
// {rw, addr[6:0], wdata[7:0]} per accepted start. On read frames it shifts
// in the last 8 bits from cipo and presents them on rdata together with done.
// Every output is a register, updated in the same edge as the state change
// that determines its value.

module spi_controller #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       rw,
   input  logic [6:0] addr,
   input  logic [7:0] wdata,
   output logic       busy,
   output logic       done,
   output logic [7:0] rdata,
   output logic       sclk,
   output logic       ncs,
   output logic       copi,
   input  logic       cipo
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETUP  = 3'd1,
      SCK_HI = 3'd2,
      SCK_LO = 3'd3,
      HOLD   = 3'd4,
      GAP    = 3'd5
   } state_t;

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   state_t      state_r;
   logic [7:0]  cnt_r;     // cycles spent in the current phase
   logic [3:0]  bit_r;     // index of the frame bit on copi, 0 = MSB
   logic [15:0] shift_r;   // outgoing frame, bit 15 is on copi
   logic        rw_r;      // frame type captured at start
   logic [7:0]  rx_r;      // incoming read data
   logic        last_s;    // final cycle of the current phase

   // Phase-end flag shared by every timed state.
   assign last_s = (cnt_r == DIV_LAST);

   // Frame sequencer: state, counters, shift registers and all outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         cnt_r   <= 8'd0;
         bit_r   <= 4'd0;
         shift_r <= 16'd0;
         rw_r    <= 1'b0;
         rx_r    <= 8'd0;
         busy    <= 1'b0;
         done    <= 1'b0;
         rdata   <= 8'd0;
         sclk    <= 1'b0;
         ncs     <= 1'b1;
         copi    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_r)
            IDLE: begin
               cnt_r <= 8'd0;
               bit_r <= 4'd0;
               if (start) begin
                  rw_r    <= rw;
                  shift_r <= {rw, addr, (rw ? wdata : 8'h00)};
                  rx_r    <= 8'd0;
                  copi    <= rw;
                  ncs     <= 1'b0;
                  sclk    <= 1'b0;
                  busy    <= 1'b1;
                  state_r <= SETUP;
               end else begin
                  ncs  <= 1'b1;
                  sclk <= 1'b0;
                  copi <= 1'b0;
                  busy <= 1'b0;
               end
            end
            SETUP: begin
               if (last_s) begin
                  cnt_r   <= 8'd0;
                  sclk    <= 1'b1;
                  state_r <= SCK_HI;
               end else begin
                  cnt_r <= cnt_r + 8'd1;
               end
            end
            SCK_HI: begin
               if (last_s) begin
                  cnt_r <= 8'd0;
                  sclk  <= 1'b0;
                  if (bit_r == 4'd15) begin
                     state_r <= HOLD;
                  end else begin
                     // Next bit goes out together with the falling sclk edge.
                     bit_r   <= bit_r + 4'd1;
                     shift_r <= {shift_r[14:0], 1'b0};
                     copi    <= shift_r[14];
                     state_r <= SCK_LO;
                  end
               end else begin
                  cnt_r <= cnt_r + 8'd1;
               end
            end
            SCK_LO: begin
               if (last_s) begin
                  cnt_r   <= 8'd0;
                  sclk    <= 1'b1;
                  state_r <= SCK_HI;
                  // Data byte occupies frame bits 8..15; sample as sclk rises.
                  if (!rw_r && bit_r[3]) begin
                     rx_r <= {rx_r[6:0], cipo};
                  end else begin
                     rx_r <= rx_r;
                  end
               end else begin
                  cnt_r <= cnt_r + 8'd1;
               end
            end
            HOLD: begin
               if (last_s) begin
                  cnt_r   <= 8'd0;
                  ncs     <= 1'b1;
                  copi    <= 1'b0;
                  done    <= 1'b1;
                  state_r <= GAP;
                  if (!rw_r) begin
                     rdata <= rx_r;
                  end else begin
                     rdata <= rdata;
                  end
               end else begin
                  cnt_r <= cnt_r + 8'd1;
               end
            end
            GAP: begin
               if (last_s) begin
                  cnt_r   <= 8'd0;
                  bit_r   <= 4'd0;
                  busy    <= 1'b0;
                  state_r <= IDLE;
               end else begin
                  cnt_r <= cnt_r + 8'd1;
               end
            end
            default: begin
               state_r <= IDLE;
               cnt_r   <= 8'd0;
               bit_r   <= 4'd0;
               busy    <= 1'b0;
               sclk    <= 1'b0;
               ncs     <= 1'b1;
               copi    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_controller.sv
// Self-checking bench for spi_controller: two instances (CLK_DIV 4 and 2),
// a bus monitor per instance that rebuilds frames from sclk/copi/ncs, and a
// simple SPI peripheral model returning a chosen byte on cipo.

module tb_spi_controller;

   localparam int D0 = 4;
   localparam int D1 = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] start_v;
   logic       rw;
   logic [6:0] addr;
   logic [7:0] wdata;
   logic [1:0] busy_v, done_v, sclk_v, ncs_v, copi_v, cipo_v;
   logic [7:0] rdata0, rdata1;

   int checks = 0;
   int errors = 0;

   // monitor state, index = instance
   int          rises [2]     = '{0, 0};
   int          last_rises [2] = '{0, 0};
   logic [15:0] bits [2]      = '{16'h0, 16'h0};
   logic [15:0] last_frame [2] = '{16'h0, 16'h0};
   int          ncs_run [2]   = '{0, 0};
   int          last_ncs [2]  = '{0, 0};
   int          hi_gap [2]    = '{0, 0};
   int          min_gap [2]   = '{1000, 1000};
   int          frames [2]    = '{0, 0};
   int          done_cnt [2]  = '{0, 0};
   logic [7:0]  done_rd [2]   = '{8'h0, 8'h0};
   int          hi_run [2]    = '{0, 0};
   int          hi_bad [2]    = '{0, 0};
   int          stab [2]      = '{0, 0};
   int          stab_bad [2]  = '{0, 0};
   logic        prev_s [2]    = '{1'b0, 1'b0};
   logic        prev_c [2]    = '{1'b0, 1'b0};
   logic        prev_n [2]    = '{1'b1, 1'b1};
   logic [7:0]  resp [2]      = '{8'h0, 8'h0};
   logic [7:0]  exp_rdata     = 8'h00;

   spi_controller #(.CLK_DIV(D0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start_v[0]), .rw(rw), .addr(addr), .wdata(wdata),
      .busy(busy_v[0]), .done(done_v[0]), .rdata(rdata0), .sclk(sclk_v[0]),
      .ncs(ncs_v[0]), .copi(copi_v[0]), .cipo(cipo_v[0]));

   spi_controller #(.CLK_DIV(D1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start_v[1]), .rw(rw), .addr(addr), .wdata(wdata),
      .busy(busy_v[1]), .done(done_v[1]), .rdata(rdata1), .sclk(sclk_v[1]),
      .ncs(ncs_v[1]), .copi(copi_v[1]), .cipo(cipo_v[1]));

   always #5 clk = ~clk;

   // Bus observer and peripheral model for one instance, sampled mid-cycle.
   task automatic mon(input int i, input int d, input logic s, input logic c,
                      input logic n, input logic dn, input logic [7:0] rd);
      int idx;
      if (c !== prev_c[i]) stab[i] = 0;
      if (!n) begin
         ncs_run[i]++;
         if (prev_n[i]) begin
            if (hi_gap[i] < min_gap[i]) min_gap[i] = hi_gap[i];
         end
      end else begin
         if (!prev_n[i]) begin
            last_ncs[i]   = ncs_run[i];
            ncs_run[i]    = 0;
            frames[i]++;
            last_frame[i] = bits[i];
            last_rises[i] = rises[i];
            rises[i]      = 0;
            hi_gap[i]     = 0;
         end
         hi_gap[i]++;
      end
      if (s && !prev_s[i]) begin
         bits[i] = {bits[i][14:0], c};
         rises[i]++;
         if (stab[i] < d) stab_bad[i]++;
         hi_run[i] = 1;
      end else if (s) begin
         hi_run[i]++;
         if (c !== prev_c[i]) stab_bad[i]++;
      end else if (prev_s[i] && !n) begin
         if (hi_run[i] != d) hi_bad[i]++;
      end
      stab[i]++;
      if (dn) begin
         done_cnt[i]++;
         done_rd[i] = rd;
      end
      // peripheral: byte MSB first, bit k of the frame presented before rise k
      if (!n && rises[i] >= 8 && rises[i] < 16) begin
         idx = 15 - rises[i];
         cipo_v[i] = resp[i][idx];
      end else begin
         cipo_v[i] = 1'b0;
      end
      prev_s[i] = s;
      prev_c[i] = c;
      prev_n[i] = n;
   endtask

   // Observe both instances on the falling edge.
   always @(negedge clk) begin
      mon(0, D0, sclk_v[0], copi_v[0], ncs_v[0], done_v[0], rdata0);
      mon(1, D1, sclk_v[1], copi_v[1], ncs_v[1], done_v[1], rdata1);
   end

   task automatic send(input int i, input logic r, input logic [6:0] a, input logic [7:0] w);
      @(posedge clk); #1;
      rw = r; addr = a; wdata = w; start_v[i] = 1'b1;
      @(posedge clk); #1;
      start_v[i] = 1'b0;
   endtask

   task automatic wait_frame(input int i, input bit scramble, output bit ok);
      int f0;
      f0 = frames[i];
      ok = 1'b0;
      for (int k = 0; k < 800; k++) begin
         @(posedge clk); #1;
         if (scramble) begin
            rw = 1'($urandom_range(0, 1)); addr = 7'($urandom); wdata = 8'($urandom);
         end
         if (frames[i] != f0 && !busy_v[i]) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++; if (ncs_v !== 2'b11)  begin errors++; $display("FAIL reset_ncs: got %b expected 11", ncs_v); end
      checks++; if (sclk_v !== 2'b00) begin errors++; $display("FAIL reset_sclk: got %b expected 00", sclk_v); end
      checks++; if (copi_v !== 2'b00) begin errors++; $display("FAIL reset_copi: got %b expected 00", copi_v); end
      checks++; if (busy_v !== 2'b00) begin errors++; $display("FAIL reset_busy: got %b expected 00", busy_v); end
      checks++; if (done_v !== 2'b00) begin errors++; $display("FAIL reset_done: got %b expected 00", done_v); end
      checks++; if (rdata0 !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h expected 00", rdata0); end
      rst_n = 1'b1;
   endtask

   task automatic test_write_basic();
      bit ok; int d0;
      d0 = done_cnt[0];
      send(0, 1'b1, 7'h00, 8'hF0);
      wait_frame(0, 1'b0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL wr_timeout: frame did not complete"); end
      checks++; if (last_frame[0] !== 16'h80F0) begin errors++; $display("FAIL wr_frame: got %h expected 80f0", last_frame[0]); end
      checks++; if (last_ncs[0] != 33 * D0) begin errors++; $display("FAIL wr_ncs_len: got %0d expected %0d", last_ncs[0], 33 * D0); end
      checks++; if (last_rises[0] != 16) begin errors++; $display("FAIL wr_rises: got %0d expected 16", last_rises[0]); end
      checks++; if (done_cnt[0] != d0 + 1) begin errors++; $display("FAIL wr_done: got %0d expected %0d", done_cnt[0], d0 + 1); end
      checks++; if (rdata0 !== exp_rdata) begin errors++; $display("FAIL wr_rdata_kept: got %h expected %h", rdata0, exp_rdata); end
   endtask

   task automatic test_read();
      bit ok;
      resp[0] = 8'hA5;
      send(0, 1'b0, 7'h04, 8'h3C);
      wait_frame(0, 1'b0, ok);
      exp_rdata = 8'hA5;
      checks++; if (!ok) begin errors++; $display("FAIL rd_timeout: frame did not complete"); end
      checks++; if (last_frame[0] !== 16'h0400) begin errors++; $display("FAIL rd_frame: got %h expected 0400", last_frame[0]); end
      checks++; if (done_rd[0] !== 8'hA5) begin errors++; $display("FAIL rd_rdata_at_done: got %h expected a5", done_rd[0]); end
      checks++; if (rdata0 !== 8'hA5) begin errors++; $display("FAIL rd_rdata: got %h expected a5", rdata0); end
   endtask

   task automatic test_random();
      bit ok; logic r; logic [6:0] a; logic [7:0] w; logic [15:0] ef; int d0;
      for (int n = 0; n < 6; n++) begin
         r = 1'($urandom_range(0, 1)); a = 7'($urandom); w = 8'($urandom);
         resp[0] = 8'($urandom);
         ef = {r, a, (r ? w : 8'h00)};
         d0 = done_cnt[0];
         send(0, r, a, w);
         wait_frame(0, 1'b1, ok);
         if (!r) exp_rdata = resp[0];
         checks++; if (!ok) begin errors++; $display("FAIL rnd_timeout[%0d]", n); end
         checks++; if (last_frame[0] !== ef) begin errors++; $display("FAIL rnd_frame[%0d]: got %h expected %h", n, last_frame[0], ef); end
         checks++; if (done_cnt[0] != d0 + 1) begin errors++; $display("FAIL rnd_done[%0d]: got %0d expected %0d", n, done_cnt[0], d0 + 1); end
         checks++; if (done_rd[0] !== exp_rdata) begin errors++; $display("FAIL rnd_rdata_at_done[%0d]: got %h expected %h", n, done_rd[0], exp_rdata); end
         checks++; if (rdata0 !== exp_rdata) begin errors++; $display("FAIL rnd_rdata[%0d]: got %h expected %h", n, rdata0, exp_rdata); end
      end
   endtask

   task automatic test_ignore_start();
      bit ok; int f0; int d0;
      f0 = frames[0]; d0 = done_cnt[0];
      send(0, 1'b1, 7'h2A, 8'h3C);
      @(posedge clk); #1;
      rw = 1'b0; addr = 7'h11; wdata = 8'hEE; start_v[0] = 1'b1;
      @(posedge clk); #1;
      start_v[0] = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(posedge clk); #1;
         if (sclk_v[0]) break;
      end
      start_v[0] = 1'b1; addr = 7'h55;
      @(posedge clk); #1;
      start_v[0] = 1'b0;
      wait_frame(0, 1'b0, ok);
      repeat (12) @(posedge clk);
      #1;
      checks++; if (!ok) begin errors++; $display("FAIL ign_timeout: frame did not complete"); end
      checks++; if (frames[0] != f0 + 1) begin errors++; $display("FAIL ign_frames: got %0d expected %0d", frames[0], f0 + 1); end
      checks++; if (done_cnt[0] != d0 + 1) begin errors++; $display("FAIL ign_done: got %0d expected %0d", done_cnt[0], d0 + 1); end
      checks++; if (last_frame[0] !== 16'hAA3C) begin errors++; $display("FAIL ign_frame: got %h expected aa3c", last_frame[0]); end
      checks++; if (ncs_v[0] !== 1'b1) begin errors++; $display("FAIL ign_idle_ncs: got %b expected 1", ncs_v[0]); end
   endtask

   task automatic test_back_to_back();
      bit ok; int f0; int d0;
      f0 = frames[0]; d0 = done_cnt[0]; min_gap[0] = 1000; ok = 1'b0;
      @(posedge clk); #1;
      rw = 1'b1; addr = 7'h33; wdata = 8'h9C; start_v[0] = 1'b1;
      for (int k = 0; k < 2000; k++) begin
         @(posedge clk); #1;
         if (done_cnt[0] >= d0 + 3) begin ok = 1'b1; break; end
      end
      start_v[0] = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(posedge clk); #1;
         if (!busy_v[0]) break;
      end
      repeat (12) @(posedge clk);
      #1;
      checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout: only %0d done pulses", done_cnt[0] - d0); end
      checks++; if (done_cnt[0] != d0 + 3) begin errors++; $display("FAIL b2b_done: got %0d expected %0d", done_cnt[0], d0 + 3); end
      checks++; if (frames[0] != f0 + 3) begin errors++; $display("FAIL b2b_frames: got %0d expected %0d", frames[0], f0 + 3); end
      checks++; if (min_gap[0] < D0 + 1) begin errors++; $display("FAIL b2b_gap: got %0d expected >= %0d", min_gap[0], D0 + 1); end
      checks++; if (last_frame[0] !== 16'hB39C) begin errors++; $display("FAIL b2b_frame: got %h expected b39c", last_frame[0]); end
   endtask

   task automatic test_reset_midframe();
      bit ok; int d0; bit hit;
      d0 = done_cnt[0]; hit = 1'b0;
      send(0, 1'b1, 7'h6B, 8'h12);
      for (int k = 0; k < 200; k++) begin
         @(posedge clk); #1;
         if (rises[0] == 7) begin hit = 1'b1; break; end
      end
      rst_n = 1'b0;
      #1;
      checks++; if (!hit) begin errors++; $display("FAIL rst_mid_timeout: 7th rise not seen"); end
      checks++; if (ncs_v[0] !== 1'b1) begin errors++; $display("FAIL rst_mid_ncs: got %b expected 1", ncs_v[0]); end
      checks++; if (sclk_v[0] !== 1'b0) begin errors++; $display("FAIL rst_mid_sclk: got %b expected 0", sclk_v[0]); end
      checks++; if (busy_v[0] !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy_v[0]); end
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_rdata = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (done_cnt[0] != d0) begin errors++; $display("FAIL rst_mid_nodone: got %0d expected %0d", done_cnt[0], d0); end
      checks++; if (rdata0 !== 8'h00) begin errors++; $display("FAIL rst_mid_rdata: got %h expected 00", rdata0); end
      send(0, 1'b1, 7'h01, 8'h55);
      wait_frame(0, 1'b0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rst_next_timeout: frame did not complete"); end
      checks++; if (last_frame[0] !== 16'h8155) begin errors++; $display("FAIL rst_next_frame: got %h expected 8155", last_frame[0]); end
      checks++; if (last_rises[0] != 16) begin errors++; $display("FAIL rst_next_rises: got %0d expected 16", last_rises[0]); end
      checks++; if (done_cnt[0] != d0 + 1) begin errors++; $display("FAIL rst_next_done: got %0d expected %0d", done_cnt[0], d0 + 1); end
   endtask

   task automatic test_div2();
      bit ok; int d1;
      d1 = done_cnt[1];
      send(1, 1'b1, 7'h7F, 8'hFF);
      wait_frame(1, 1'b0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL div2_timeout: frame did not complete"); end
      checks++; if (last_frame[1] !== 16'hFFFF) begin errors++; $display("FAIL div2_frame: got %h expected ffff", last_frame[1]); end
      checks++; if (last_ncs[1] != 33 * D1) begin errors++; $display("FAIL div2_ncs_len: got %0d expected %0d", last_ncs[1], 33 * D1); end
      checks++; if (last_rises[1] != 16) begin errors++; $display("FAIL div2_rises: got %0d expected 16", last_rises[1]); end
      checks++; if (done_cnt[1] != d1 + 1) begin errors++; $display("FAIL div2_done: got %0d expected %0d", done_cnt[1], d1 + 1); end
   endtask

   task automatic test_timing_totals();
      checks++; if (hi_bad[0] != 0) begin errors++; $display("FAIL hi_phase_div4: %0d bad high phases, expected 0", hi_bad[0]); end
      checks++; if (stab_bad[0] != 0) begin errors++; $display("FAIL copi_stable_div4: %0d violations, expected 0", stab_bad[0]); end
      checks++; if (hi_bad[1] != 0) begin errors++; $display("FAIL hi_phase_div2: %0d bad high phases, expected 0", hi_bad[1]); end
      checks++; if (stab_bad[1] != 0) begin errors++; $display("FAIL copi_stable_div2: %0d violations, expected 0", stab_bad[1]); end
   endtask

   initial begin
      rst_n = 1'b0; start_v = 2'b00; rw = 1'b0; addr = 7'h00; wdata = 8'h00;
      test_reset();
      test_write_basic();
      test_read();
      test_random();
      test_ignore_start();
      test_back_to_back();
      test_reset_midframe();
      test_div2();
      test_timing_totals();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
